// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC result path.
// Q2.12 word format, pipeline latencies, result pair struct.
package cordic_pkg;

  localparam int DATA_WIDTH = 15;
  localparam int FRAC_BITS  = 12;
  localparam int ONE        = 1 << FRAC_BITS;
  localparam int THETA_LAT  = 13;
  localparam int MAG_LAT    = 14;
  localparam int FIFO_DEPTH = 4;

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    word_t mag;
    word_t theta;
  } res_t;

endpackage

// File: rtl/cordic_res_fifo.sv
// Show-ahead result FIFO, DEPTH x {mag, theta}, async active-low reset.
// Ports: clk, rst_n, push/wdata, pop, rdata (head), level (occupancy).
module cordic_res_fifo
  import cordic_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  res_t          wdata,
  input  logic          pop,
  output res_t          rdata,
  output logic [LW-1:0] level
);

  res_t          mem_q [DEPTH];
  res_t          mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q + LW'(push) - LW'(pop);
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign level = lvl_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && lvl_q == LW'(DEPTH))
  );

endmodule

// File: rtl/cordic_result_buffer.sv
// Tracks sample validity through the valid-less CORDIC pipeline and buffers results.
// Ports: in_valid/in_ready, core_theta/core_mag, out_valid/out_ready, out_*, level, drop_err.
module cordic_result_buffer
  import cordic_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] core_theta,
  input  logic [DATA_WIDTH-1:0] core_mag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_mag,
  output logic [DATA_WIDTH-1:0] out_theta,
  output logic [LW-1:0]         level,
  output logic                  drop_err
);

  logic [MAG_LAT-1:0]    vld_q, vld_d;
  logic [DATA_WIDTH-1:0] theta_q, theta_d;
  logic [LW-1:0]         infl_q, infl_d;
  logic                  drop_q, drop_d;
  logic [LW:0]           used;
  logic                  accept;
  logic                  push;
  logic                  pop;
  res_t                  wdata;
  res_t                  head;

  // Credit counts buffered plus in-flight results; a pop this
  // cycle only frees a slot once level has updated.
  always_comb begin
    used     = {1'b0, level} + {1'b0, infl_q};
    in_ready = rst & (used < (LW+1)'(DEPTH));
    accept   = in_valid & in_ready;
    push     = vld_q[MAG_LAT-1];
    pop      = out_valid & out_ready;
    vld_d    = {vld_q[MAG_LAT-2:0], accept};
    theta_d  = vld_q[THETA_LAT-1] ? core_theta : theta_q;
    infl_d   = infl_q + LW'(accept) - LW'(push);
    drop_d   = drop_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      theta_q <= '0;
      infl_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      theta_q <= theta_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
    end
  end

  assign wdata.mag   = core_mag;
  assign wdata.theta = theta_q;

  cordic_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .level (level)
  );

  assign out_valid = (level != '0);
  assign out_mag   = head.mag;
  assign out_theta = head.theta;
  assign drop_err  = drop_q;

endmodule
